// File: rtl/ioexp_pkg.sv
// Shared types and constants for the 8243-style I/O expander.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ioexp_pkg;

  // Two-bit opcode carried in P2[3:2] on the PROG falling edge.
  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_OR    = 2'b10,
    CMD_AND   = 2'b11
  } cmd_e;

  // Port selector carried in P2[1:0]; the physical port number is addr+4.
  localparam logic [1:0] PORT4 = 2'd0;
  localparam logic [1:0] PORT5 = 2'd1;
  localparam logic [1:0] PORT6 = 2'd2;
  localparam logic [1:0] PORT7 = 2'd3;

  // P7 bits whose falling edge acknowledges a TX byte / strobes an RX byte.
  localparam int P7_TX_ACK = 1;
  localparam int P7_RX_STB = 2;

  // Result of a meter write-class op on the P7 control register.
  function automatic logic [3:0] p7_apply(input cmd_e cmd, input logic [3:0] cur,
                                          input logic [3:0] dat);
    logic [3:0] res;
    res = cur;
    case (cmd)
      CMD_WRITE: res = dat;
      CMD_OR:    res = cur | dat;
      CMD_AND:   res = cur & dat;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ioexp_fifo.sv
// Generic synchronous FIFO with head-of-queue visibility and occupancy count.
// Latency: a pushed word is visible at head_dat one clock after the push.
// Backpressure: push ignored while full, pop ignored while empty; both in one cycle is legal.
module ioexp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = LW'(wr_ptr - rd_ptr);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer advance; wraps naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ioexp_buf.sv
// 8243-style I/O expander bridging the meter PROG/P2 bus to UART byte FIFOs.
// Latency: read data/oe SYNC_STAGES+1 clks after PROG falls; writes land SYNC_STAGES+1 clks after PROG rises.
// Backpressure: tx_ready drops when TX FIFO full; RX bytes pushed into a full FIFO are dropped and flagged.
module ioexp_buf
  import ioexp_pkg::*;
#(
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [3:0]                        p2i,
  output logic [3:0]                        p2o,
  input  logic                              prog_n,
  output logic                              p2_oe,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [7:0]                        rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic                              rx_overflow,
  input  logic                              ovf_clr,
  output logic [$clog2(TX_DEPTH+1)-1:0]     tx_level,
  output logic [$clog2(RX_DEPTH+1)-1:0]     rx_level
);

  logic [SYNC_STAGES-1:0] prog_sync;
  logic [3:0]             p2i_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] smp_vld;
  logic                   prog_n_s;
  logic [3:0]             p2i_s;
  logic                   prog_q;
  logic [3:0]             p2i_q;
  logic                   armed;
  logic                   fall;
  logic                   rise;

  cmd_e                   cmd;
  logic [1:0]             addr;
  logic                   rd_phase;
  logic [3:0]             p7;
  logic [3:0]             stage_lo;
  logic [3:0]             stage_hi;
  logic [3:0]             p7_nxt;
  logic [3:0]             lo_nxt;
  logic [3:0]             hi_nxt;
  logic                   tx_pop;
  logic                   rx_push;

  logic [7:0]             tx_head;
  logic                   tx_full;
  logic                   tx_empty;
  logic                   rx_full;
  logic                   rx_empty;

  // Synchronisers for PROG and P2; smp_vld marks when the last stage holds a real pin sample
  // rather than its reset value, so a PROG held low through reset never looks like a fall.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prog_sync <= '1;
      smp_vld   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) p2i_sync[i] <= 4'hF;
    end else begin
      prog_sync   <= {prog_sync[SYNC_STAGES-2:0], prog_n};
      smp_vld     <= {smp_vld[SYNC_STAGES-2:0], 1'b1};
      p2i_sync[0] <= p2i;
      for (int i = 1; i < SYNC_STAGES; i++) p2i_sync[i] <= p2i_sync[i-1];
    end
  end

  assign prog_n_s = prog_sync[SYNC_STAGES-1];
  assign p2i_s    = p2i_sync[SYNC_STAGES-1];

  // One-cycle history for edge detection and arming once PROG is genuinely seen high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prog_q <= 1'b1;
      p2i_q  <= 4'hF;
      armed  <= 1'b0;
    end else begin
      prog_q <= prog_n_s;
      p2i_q  <= p2i_s;
      if (smp_vld[SYNC_STAGES-1] && prog_n_s) armed <= 1'b1;
    end
  end

  // p2i_q is the sample from the last cycle before the edge, i.e. the settled nibble.
  assign fall = armed &  prog_q & ~prog_n_s;
  assign rise = armed & ~prog_q &  prog_n_s;

  // Latch the command/port on PROG fall and track whether the meter is reading.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cmd      <= CMD_READ;
      addr     <= PORT4;
      rd_phase <= 1'b0;
    end else if (fall) begin
      cmd      <= cmd_e'(p2i_q[3:2]);
      addr     <= p2i_q[1:0];
      rd_phase <= (cmd_e'(p2i_q[3:2]) == CMD_READ);
    end else if (rise) begin
      rd_phase <= 1'b0;
    end
  end

  // Execute the latched op against the data nibble on PROG rise; OR/AND only affect P7.
  always_comb begin
    p7_nxt = p7;
    lo_nxt = stage_lo;
    hi_nxt = stage_hi;
    if (rise) begin
      if (addr == PORT7) begin
        p7_nxt = p7_apply(cmd, p7, p2i_q);
      end else if (cmd == CMD_WRITE) begin
        if (addr == PORT4) lo_nxt = p2i_q;
        if (addr == PORT5) hi_nxt = p2i_q;
      end
    end
  end

  assign tx_pop  = p7[P7_TX_ACK] & ~p7_nxt[P7_TX_ACK];
  assign rx_push = p7[P7_RX_STB] & ~p7_nxt[P7_RX_STB];

  // Port registers written by meter ops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p7       <= 4'hF;
      stage_lo <= 4'h0;
      stage_hi <= 4'h0;
    end else begin
      p7       <= p7_nxt;
      stage_lo <= lo_nxt;
      stage_hi <= hi_nxt;
    end
  end

  // Sticky overflow; a new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  rx_overflow <= 1'b0;
    else if (rx_push & rx_full) rx_overflow <= 1'b1;
    else if (ovf_clr)           rx_overflow <= 1'b0;
  end

  // Readback mux follows the latched port; P6 reports FIFO status to the meter.
  always_comb begin
    p2o = 4'h0;
    case (addr)
      PORT4:   p2o = tx_empty ? 4'h0 : tx_head[3:0];
      PORT5:   p2o = tx_empty ? 4'h0 : tx_head[7:4];
      PORT6:   p2o = {rx_full, 1'b1, 1'b0, tx_empty};
      default: p2o = p7;
    endcase
  end

  // Raw prog_n so the meter gets the bus back the instant it raises PROG.
  assign p2_oe = rd_phase & ~prog_n;

  assign tx_ready = ~tx_full;
  assign rx_valid = ~rx_empty;

  ioexp_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (tx_valid & ~tx_full),
    .push_dat (tx_data),
    .pop      (tx_pop),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .level    (tx_level)
  );

  ioexp_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (rx_push),
    .push_dat ({stage_hi, stage_lo}),
    .pop      (rx_ready & ~rx_empty),
    .head_dat (rx_data),
    .full     (rx_full),
    .empty    (rx_empty),
    .level    (rx_level)
  );

endmodule

// File: tb/tb_ioexp_buf.sv
// Directed plus randomized bench for ioexp_buf with a queue-based reference model.
// Latency: meter ops are driven slowly enough for the synchroniser to settle each phase.
// Backpressure: UART pushes honour tx_ready expectations from the model.
`timescale 1ns/1ps
module tb_ioexp_buf;

  localparam int S   = 2;
  localparam int TXD = 8;
  localparam int RXD = 8;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, OR_ = 2'b10, AND_ = 2'b11;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] p2i;
  logic [3:0] p2o;
  logic       prog_n;
  logic       p2_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overflow;
  logic       ovf_clr;
  logic [3:0] tx_level;
  logic [3:0] rx_level;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [3:0] p7_m;
  logic [3:0] lo_m;
  logic [3:0] hi_m;
  logic       ovf_m;
  logic [3:0] rdv;

  ioexp_buf #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .p2i         (p2i),
    .p2o         (p2o),
    .prog_n      (prog_n),
    .p2_oe       (p2_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow),
    .ovf_clr     (ovf_clr),
    .tx_level    (tx_level),
    .rx_level    (rx_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    p7_m  = 4'hF;
    lo_m  = 4'h0;
    hi_m  = 4'h0;
    ovf_m = 1'b0;
  endtask

  function automatic logic [3:0] exp_read(input logic [1:0] a);
    logic [7:0] h;
    h = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    case (a)
      2'd0:    return h[3:0];
      2'd1:    return h[7:4];
      2'd2:    return {rx_q.size() == RXD, 1'b1, 1'b0, tx_q.size() == 0};
      default: return p7_m;
    endcase
  endfunction

  // Spec rules in plain terms: new P7 value, then edge-triggered pop/push.
  task automatic model_apply(input logic [1:0] c, input logic [1:0] a, input logic [3:0] d);
    logic [3:0] np;
    np = p7_m;
    if (a == 2'd3) begin
      if (c == WR)   np = d;
      if (c == OR_)  np = p7_m | d;
      if (c == AND_) np = p7_m & d;
    end
    if (c == WR && a == 2'd0) lo_m = d;
    if (c == WR && a == 2'd1) hi_m = d;
    if (p7_m[1] && !np[1] && tx_q.size() > 0) void'(tx_q.pop_front());
    if (p7_m[2] && !np[2]) begin
      if (rx_q.size() == RXD) ovf_m = 1'b1;
      else rx_q.push_back({hi_m, lo_m});
    end
    p7_m = np;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".tx_level"}, tx_level, tx_q.size());
    chk({tag, ".rx_level"}, rx_level, rx_q.size());
    chk({tag, ".tx_ready"}, tx_ready, tx_q.size() < TXD);
    chk({tag, ".rx_valid"}, rx_valid, rx_q.size() > 0);
    chk({tag, ".rx_ovf"},   rx_overflow, ovf_m);
    if (rx_q.size() > 0) chk({tag, ".rx_data"}, rx_data, rx_q[0]);
  endtask

  task automatic meter(input logic [1:0] c, input logic [1:0] a, input logic [3:0] d,
                       output logic [3:0] rd);
    logic [3:0] exp_rd;
    exp_rd = exp_read(a);
    p2i = {c, a};
    tick(S + 2);
    prog_n = 1'b0;
    tick(S + 1);
    rd = p2o;
    chk("p2_oe_during_op", p2_oe, c == RD);
    if (c == RD) chk($sformatf("read_P%0d", a + 4), rd, exp_rd);
    p2i = d;
    tick(S + 1);
    prog_n = 1'b1;
    #1;
    chk("p2_oe_release", p2_oe, 1'b0);
    tick(S + 2);
    model_apply(c, a, d);
    chk_state($sformatf("op%0d_P%0d", c, a + 4));
  endtask

  task automatic uart_push(input logic [7:0] b);
    chk("tx_ready_pre_push", tx_ready, tx_q.size() < TXD);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    if (tx_q.size() < TXD) tx_q.push_back(b);
    chk("tx_level_post_push", tx_level, tx_q.size());
  endtask

  task automatic uart_pop();
    chk("rx_valid_pre_pop", rx_valid, rx_q.size() > 0);
    if (rx_q.size() > 0) chk("rx_data_pre_pop", rx_data, rx_q[0]);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    if (rx_q.size() > 0) void'(rx_q.pop_front());
    chk("rx_level_post_pop", rx_level, rx_q.size());
  endtask

  // Meter consumes the TX head: read both nibbles, then drop P7[1].
  task automatic meter_pop_tx();
    meter(RD, 2'd0, 4'h0, rdv);
    meter(RD, 2'd1, 4'h0, rdv);
    meter(OR_, 2'd3, 4'h2, rdv);
    meter(AND_, 2'd3, 4'hD, rdv);
  endtask

  // Meter stages a byte and strobes it into the RX FIFO.
  task automatic meter_push_rx(input logic [7:0] b);
    meter(WR, 2'd0, b[3:0], rdv);
    meter(WR, 2'd1, b[7:4], rdv);
    meter(AND_, 2'd3, 4'hB, rdv);
    meter(OR_, 2'd3, 4'h4, rdv);
  endtask

  initial begin
    nrst     = 1'b0;
    prog_n   = 1'b1;
    p2i      = 4'h0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    ovf_clr  = 1'b0;
    model_reset();
    tick(3);

    // Reset state
    chk("rst_p2_oe", p2_oe, 1'b0);
    chk_state("rst");
    nrst = 1'b1;
    tick(S + 2);

    // 1. TX byte visible to meter, then acknowledged
    uart_push(8'hA5);
    meter(RD, 2'd2, 4'h0, rdv);
    chk("t1_P6", rdv, 4'b0100);
    meter(RD, 2'd0, 4'h0, rdv);
    chk("t1_P4", rdv, 4'h5);
    meter(RD, 2'd1, 4'h0, rdv);
    chk("t1_P5", rdv, 4'hA);
    meter(RD, 2'd3, 4'h0, rdv);
    chk("t1_P7_reset", rdv, 4'hF);
    meter(AND_, 2'd3, 4'hD, rdv);
    chk("t1_tx_level", tx_level, 0);
    meter(RD, 2'd2, 4'h0, rdv);
    chk("t1_P6_empty", rdv, 4'b0101);

    // 2. Meter sends a byte upstream
    meter(OR_, 2'd3, 4'h2, rdv);
    meter(WR, 2'd0, 4'h3, rdv);
    meter(WR, 2'd1, 4'hC, rdv);
    meter(AND_, 2'd3, 4'hB, rdv);
    chk("t2_rx_valid", rx_valid, 1'b1);
    chk("t2_rx_data", rx_data, 8'hC3);
    meter(OR_, 2'd3, 4'h4, rdv);
    meter(RD, 2'd3, 4'h0, rdv);
    chk("t2_P7", rdv, 4'hF);
    uart_pop();
    chk("t2_rx_valid_after", rx_valid, 1'b0);

    // 3. RX fill, overflow, clear, drain
    for (int i = 0; i < RXD; i++) meter_push_rx(8'($urandom));
    meter(RD, 2'd2, 4'h0, rdv);
    chk("t3_P6_full", rdv[3], 1'b1);
    meter(AND_, 2'd3, 4'hB, rdv);
    chk("t3_ovf", rx_overflow, 1'b1);
    chk("t3_rx_level", rx_level, RXD);
    meter(OR_, 2'd3, 4'h4, rdv);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    ovf_m   = 1'b0;
    chk("t3_ovf_clr", rx_overflow, 1'b0);
    for (int i = 0; i < RXD; i++) uart_pop();

    // 4. Empty-TX ack, then simultaneous pop and push
    meter(AND_, 2'd3, 4'hD, rdv);
    chk("t4_no_underflow", tx_level, 0);
    meter(OR_, 2'd3, 4'h2, rdv);
    uart_push(8'h3C);
    meter(WR, 2'd0, 4'hA, rdv);
    meter(WR, 2'd1, 4'h5, rdv);
    meter(WR, 2'd3, 4'h9, rdv);
    chk("t4_tx_popped", tx_level, 0);
    chk("t4_rx_data", rx_data, 8'h5A);
    meter(OR_, 2'd3, 4'h6, rdv);
    uart_pop();

    // 6. TX overfill interleaved with meter pops; order across wrap
    for (int i = 0; i < TXD + 3; i++) begin
      uart_push(8'($urandom));
      if (i % 4 == 3) meter_pop_tx();
    end
    chk("t6_full_ready", tx_ready, 1'b0);
    while (tx_q.size() > 0) meter_pop_tx();
    chk("t6_drained_ready", tx_ready, 1'b1);

    // Randomized mix of UART and meter traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: uart_push(8'($urandom));
        1: uart_pop();
        default: meter(2'($urandom), 2'($urandom), 4'($urandom), rdv);
      endcase
    end

    // 5. PROG low through reset release, then reset mid-read
    prog_n = 1'b0;
    p2i    = {RD, 2'd3};
    nrst   = 1'b0;
    model_reset();
    tick(2);
    nrst = 1'b1;
    tick(S + 4);
    chk("t5_held_low_oe", p2_oe, 1'b0);
    chk_state("t5_after_rst");
    prog_n = 1'b1;
    tick(S + 3);
    meter(WR, 2'd3, 4'h3, rdv);
    meter(RD, 2'd3, 4'h0, rdv);
    chk("t5_P7_armed", rdv, 4'h3);
    p2i = {RD, 2'd3};
    tick(S + 2);
    prog_n = 1'b0;
    tick(S + 1);
    chk("t5_mid_read_oe", p2_oe, 1'b1);
    nrst = 1'b0;
    #1;
    chk("t5_async_oe_drop", p2_oe, 1'b0);
    model_reset();
    prog_n = 1'b1;
    tick(2);
    nrst = 1'b1;
    tick(S + 3);
    chk_state("t5_after_rst2");
    meter(RD, 2'd3, 4'h0, rdv);
    chk("t5_P7_reset", rdv, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
